// File: rtl/alu_multicycle.sv
// alu_multicycle: iterative unsigned multiply/divide unit for the Execute stage.
// Computes MUL, MULHU, DIVU and REMU one bit per cycle and holds alu_ready low
// while an operation is in flight so the hazard unit stalls Execute and upstream.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        multicycle op present in Execute
//   op           00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   src_a        multiplicand / dividend
//   src_b        multiplier / divisor
//   hold         Execute stall from the hazard unit
//   flush        abort the current operation
//   alu_ready    result valid or nothing pending; low stalls Execute
//   busy         iteration in progress
//   result       selected result, held until the next accepted op completes
//   div_by_zero  DIVU/REMU divisor was zero, held alongside result
//
// Build option:
//   ALU_EARLY_TERM_EN  when defined, MUL/MULHU finish as soon as the remaining
//                      multiplier bits are all zero (minimum one BUSY cycle).
module alu_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hold,
    input  logic             flush,
    output logic             alu_ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    // Multiply: product accumulator. Divide: low WIDTH bits hold the partial remainder.
    logic [2*WIDTH-1:0] acc_q;
    // Multiply: multiplicand shifted left each step. Divide: divisor in the low half.
    logic [2*WIDTH-1:0] dsr_q;
    // Multiply: multiplier shifted right. Divide: dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0]   sh_q;
    logic               dbz_q;

    logic               is_mul;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   rem_diff;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH-1:0]   final_result;
    logic               last_iter;

    assign is_mul = ~op_q[1];

    always_comb begin
        mul_acc   = sh_q[0] ? (acc_q + dsr_q) : acc_q;
        rem_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        // Extra top bit is the borrow: set means the divisor does not fit.
        rem_diff  = {1'b0, rem_shift} - {2'b00, dsr_q[WIDTH-1:0]};
        if (rem_diff[WIDTH+1]) begin
            rem_next  = rem_shift;
            quot_next = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_next  = rem_diff[WIDTH:0];
            quot_next = {sh_q[WIDTH-2:0], 1'b1};
        end

        final_result = '0;
        unique case (op_q)
            OpMul:   final_result = mul_acc[WIDTH-1:0];
            OpMulhu: final_result = mul_acc[2*WIDTH-1:WIDTH];
            OpDivu:  final_result = quot_next;
            OpRemu:  final_result = rem_next[WIDTH-1:0];
        endcase
    end

`ifdef ALU_EARLY_TERM_EN
    // Bits above the one consumed this cycle are all zero: nothing left to add.
    assign last_iter = (cnt_q == LastIter) || (is_mul && (sh_q[WIDTH-1:1] == '0));
`else
    assign last_iter = (cnt_q == LastIter);
`endif

    always_comb begin
        alu_ready = 1'b0;
        unique case (state_q)
            StIdle:  alu_ready = ~start;
            StBusy:  alu_ready = 1'b0;
            StDone:  alu_ready = 1'b1;
            default: alu_ready = 1'b0;
        endcase
    end

    assign busy = (state_q == StBusy);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OpMul;
            acc_q       <= '0;
            dsr_q       <= '0;
            sh_q        <= '0;
            dbz_q       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q  <= op;
                        cnt_q <= '0;
                        acc_q <= '0;
                        if (!op[1]) begin
                            dsr_q <= {{WIDTH{1'b0}}, src_a};
                            sh_q  <= src_b;
                        end else begin
                            dsr_q <= {{WIDTH{1'b0}}, src_b};
                            sh_q  <= src_a;
                        end
                        dbz_q   <= op[1] && (src_b == '0);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_mul) begin
                        acc_q <= mul_acc;
                        dsr_q <= dsr_q << 1;
                        sh_q  <= sh_q >> 1;
                    end else begin
                        acc_q <= {{(WIDTH-1){1'b0}}, rem_next};
                        sh_q  <= quot_next;
                    end
                    if (last_iter) begin
                        result      <= final_result;
                        div_by_zero <= dbz_q;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // Same instruction still in Execute while held; start is ignored.
                    if (!hold) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32). A behavioural model of
// latency and results is checked against the DUT every cycle; directed ops are
// also checked against hand-computed literal results and stall lengths.
module tb_alu_multicycle;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          hold;
    logic          flush;
    logic          alu_ready;
    logic          busy;
    logic [W-1:0]  result;
    logic          div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ALU_EARLY_TERM_EN
    localparam int StallMul76 = 4;
`else
    localparam int StallMul76 = 33;
`endif

    alu_multicycle #(.WIDTH(32), .CNT_W(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hold        (hold),
        .flush       (flush),
        .alu_ready   (alu_ready),
        .busy        (busy),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference straight from the operation definitions.
    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int busy_cycles(input logic [1:0] o, input logic [W-1:0] b);
        int n;
        n = W;
`ifdef ALU_EARLY_TERM_EN
        if (!o[1]) begin
            n = 1;
            for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Model: 0 = idle, 1 = computing, 2 = result presented.
    int           m_st   = 0;
    int           m_left = 0;
    logic [W-1:0] m_res  = '0;
    logic         m_dbz  = 1'b0;
    logic [W-1:0] p_res  = '0;
    logic         p_dbz  = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_st  = 0;
            m_res = '0;
            m_dbz = 1'b0;
        end else if (flush) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (start) begin
                p_res  = ref_result(op, src_a, src_b);
                p_dbz  = op[1] && (src_b == 0);
                m_left = busy_cycles(op, src_b);
                m_st   = 1;
            end
        end else if (m_st == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_res = p_res;
                m_dbz = p_dbz;
                m_st  = 2;
            end
        end else if (!hold) begin
            m_st = 0;
        end
    end

    always @(negedge clock) begin
        check("model_ready", {63'b0, alu_ready}, {63'b0, (m_st == 0) ? !start : (m_st == 2)});
        check("model_busy", {63'b0, busy}, {63'b0, m_st == 1});
        check("model_result", {32'b0, result}, {32'b0, m_res});
        check("model_dbz", {63'b0, div_by_zero}, {63'b0, m_dbz});
    end

    // Present an op and wait for alu_ready; checks literal result, flag and stall length.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] lit, input logic lit_dbz,
                          input int lit_stall);
        int  stall;
        bit  seen;
        stall = 0;
        seen  = 0;
        @(posedge clock);
        #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (alu_ready) begin
                seen = 1;
                break;
            end
            stall++;
            if (i == 1) begin
                // Operands are captured at acceptance; later changes must not matter.
                #2;
                src_a = ~a;
                src_b = b ^ 32'h0000_0005;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: alu_ready never rose, expected within 200 cycles", name);
        end
        check({name, "_result"}, {32'b0, result}, {32'b0, lit});
        check({name, "_dbz"}, {63'b0, div_by_zero}, {63'b0, lit_dbz});
        check({name, "_stall"}, 64'(stall), 64'(lit_stall));
    endtask

    task automatic release_op();
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        src_a   = '0;
        src_b   = '0;
        hold    = 1'b0;
        flush   = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clock);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_result", {32'b0, result}, 64'd0);
        check("reset_ready", {63'b0, alu_ready}, 64'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, StallMul76);
        release_op();
        run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        release_op();
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        release_op();

        // Hold through BUSY and DONE with start kept high: no restart.
        hold = 1'b1;
        run_op("hold_mul", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, StallMul76);
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_ready", {63'b0, alu_ready}, 64'd1);
            check("hold_busy", {63'b0, busy}, 64'd0);
            check("hold_result", {32'b0, result}, 64'd42);
        end
        @(posedge clock);
        #1;
        hold  = 1'b0;
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("idle_after_hold_ready", {63'b0, alu_ready}, 64'd1);
        @(posedge clock);
        #1;
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clock);
        check("represent_ready", {63'b0, alu_ready}, 64'd0);

        // Flush during BUSY cycle 10: back to IDLE, result untouched.
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(negedge clock);
        check("flush_pre_busy", {63'b0, busy}, 64'd1);
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_ready", {63'b0, alu_ready}, 64'd1);
        check("flush_result", {32'b0, result}, 64'd42);

        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        release_op();
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        release_op();
        run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 33);
        release_op();
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 33);
        release_op();

        // Asynchronous reset in the middle of BUSY.
        @(posedge clock);
        #1;
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'h1234_5678;
        src_b = 32'h8765_4321;
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("async_busy", {63'b0, busy}, 64'd0);
        check("async_result", {32'b0, result}, 64'd0);
        check("async_dbz", {63'b0, div_by_zero}, 64'd0);
        check("async_ready_start", {63'b0, alu_ready}, 64'd0);
        start = 1'b0;
        #1;
        check("async_ready_idle", {63'b0, alu_ready}, 64'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;

        run_op("mul_after_reset", 2'b00, 32'd3, 32'd5, 32'd15, 1'b0, `ifdef ALU_EARLY_TERM_EN 4 `else 33 `endif);
        release_op();
        repeat (2) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Iterative multiply/divide unit in the Execute stage. It is the producer of `x_alu_ready`, which the hazard detection unit consumes: the unit holds `alu_ready` low while an operation is in flight, so Execute and the upstream stages stall.
- It obeys the stall (`hold`) and flush (`flush`) controls that the hazard unit drives back.
- Unsigned MUL, MULHU, DIVU and REMU, one bit per cycle.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  multicycle op present in Execute (decode of x_reg_write & mul/div opcode).
- op  input  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- src_a  input  WIDTH  multiplicand / dividend.
- src_b  input  WIDTH  multiplier / divisor.
- hold  input  1  Execute stall from the hazard unit (x_stall excluding self-stall).
- flush  input  1  abort the current operation (jump_haz).
- alu_ready  output  1  result valid, or no op pending; low means stall Execute.
- busy  output  1  state is BUSY.
- result  output  WIDTH  selected result.
- div_by_zero  output  1  sticky with result: the DIVU/REMU divisor was 0.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, reset_n=0) forces IDLE, counter=0, result=0, div_by_zero=0, busy=0.
- alu_ready:
  - IDLE: alu_ready = ~start, combinational. The cycle an op enters Execute already sees alu_ready=0; no bubble cycle is allowed.
  - BUSY: alu_ready = 0.
  - DONE: alu_ready = 1.
- IDLE transitions:
  - start=1 & flush=0: latch src_a, src_b, op; counter=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: one iteration per cycle, counter increments. After WIDTH iterations, write result and go to DONE.
  - Latency: accepted at cycle 0, BUSY cycles 1..WIDTH, DONE at cycle WIDTH+1. With WIDTH=32 that is a 33-cycle stall.
- MUL/MULHU: shift-add over a 2*WIDTH-bit accumulator.
  - MUL returns product[WIDTH-1:0].
  - MULHU returns product[2*WIDTH-1:WIDTH].
- DIVU/REMU: restoring division with a WIDTH+1-bit partial remainder.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divisor 0: quotient = all ones, remainder = dividend, div_by_zero=1. Still takes the full latency, with no early exit.
- DONE:
  - hold=1: stay in DONE; result and alu_ready=1 stable; start is ignored (same instruction still in Execute, so no restart).
  - hold=0: return to IDLE next cycle. A new op may be presented in the following cycle; back-to-back ops see alu_ready=0 immediately in IDLE.
- result and div_by_zero hold their value from DONE until the next accepted op completes. They are cleared only by reset.
- flush=1 has priority over everything except reset: from any state, go to IDLE next cycle; result is not updated. If start and flush are both 1 in IDLE, the op is not accepted.
- hold=1 in BUSY has no effect: iteration continues, because the self-stall is already implied.
- Operand capture: src_a and src_b are sampled only at acceptance. Later changes do not matter.

Optional Feature:
- ALU_EARLY_TERM_EN:
  - Defined: MUL/MULHU leave BUSY as soon as the remaining unshifted multiplier bits are all zero, with a minimum of 1 BUSY cycle. Results are identical to the full-latency version. DIVU/REMU are unaffected.
  - Undefined: every op takes exactly WIDTH BUSY cycles.

Test Plan:
- Reset: reset_n=0 asserted mid-BUSY -> same cycle busy=0, result=0, div_by_zero=0; alu_ready=~start.
- MUL 7*6 (WIDTH=32): alu_ready=0 from the start cycle for 33 cycles, then DONE with result=42, alu_ready=1. Under ALU_EARLY_TERM_EN, 7*6 completes in 3 BUSY cycles.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MUL on the same operands -> result=0x00000001.
- Division:
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - DIVU 5/0 -> 0xFFFFFFFF with div_by_zero=1.
  - REMU 5/0 -> 5 with div_by_zero=1.
- Hold in DONE: hold=1 for 4 cycles with start=1 -> state stays DONE, result stable, no restart. After hold drops, IDLE with alu_ready=0 only if start is re-presented.
- Flush: flush=1 at BUSY cycle 10 -> IDLE next cycle, result keeps its previous value; a new op accepted afterwards completes normally.
